// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: access-size codes, FSM
// encoding, byte-enable constants and small decode helpers.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef L_S_MODE_W
`define L_S_MODE_W 3
`endif
`ifndef L_S_WORD
`define L_S_WORD   3'd0
`define L_S_HALF   3'd1
`define L_S_HALF_U 3'd2
`define L_S_BYTE   3'd3
`define L_S_BYTE_U 3'd4
`endif

package dmem_ctrl_pkg;

    localparam int unsigned LsModeW = `L_S_MODE_W;
    localparam int unsigned BeW     = 4;

    localparam logic [LsModeW-1:0] LsWord  = `L_S_WORD;
    localparam logic [LsModeW-1:0] LsHalf  = `L_S_HALF;
    localparam logic [LsModeW-1:0] LsHalfU = `L_S_HALF_U;
    localparam logic [LsModeW-1:0] LsByte  = `L_S_BYTE;
    localparam logic [LsModeW-1:0] LsByteU = `L_S_BYTE_U;

    localparam logic [BeW-1:0] BeWord   = 4'b1111;
    localparam logic [BeW-1:0] BeHalfLo = 4'b0011;
    localparam logic [BeW-1:0] BeHalfHi = 4'b1100;
    localparam logic [BeW-1:0] BeByte0  = 4'b0001;

    typedef enum logic [1:0] {
        StIdle,
        StStore,
        StLoad,
        StDone
    } dmem_state_e;

    function automatic logic mode_valid(input logic [LsModeW-1:0] mode);
        return (mode == LsWord) || (mode == LsHalf) || (mode == LsHalfU) ||
               (mode == LsByte) || (mode == LsByteU);
    endfunction

    // Address low bits that must be zero for the given access size.
    function automatic logic misaligned(input logic [LsModeW-1:0] mode,
                                        input logic [1:0]         addr);
        logic mis;
        mis = 1'b0;
        if (mode == LsWord) begin
            mis = (addr != 2'b00);
        end else if ((mode == LsHalf) || (mode == LsHalfU)) begin
            mis = addr[0];
        end
        return mis;
    endfunction

endpackage

// File: rtl/dmem_ctrl_lane.sv
// Combinational byte-lane steering: byte enables, store-data replication and
// load-data right alignment (zero-filled) for the selected access size.
module dmem_ctrl_lane
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [LsModeW-1:0] mode_i,
    input  logic [1:0]         addr_i,
    input  logic [W-1:0]       s_data_i,
    input  logic [W-1:0]       rdata_i,
    output logic [BeW-1:0]     be_o,
    output logic [W-1:0]       wdata_o,
    output logic [W-1:0]       rdata_o
);

    logic [W-1:0] shifted;

    // Decode size into lane enables, replicated write data and aligned read data.
    always_comb begin
        be_o    = '0;
        wdata_o = s_data_i;
        rdata_o = rdata_i;
        shifted = rdata_i;
        case (mode_i)
            LsWord: begin
                be_o    = BeWord;
                wdata_o = s_data_i;
                rdata_o = rdata_i;
            end
            LsHalf, LsHalfU: begin
                // Halves ignore addr[0]; only addr[1] picks the lane pair.
                be_o    = addr_i[1] ? BeHalfHi : BeHalfLo;
                wdata_o = {(W/16){s_data_i[15:0]}};
                shifted = rdata_i >> {addr_i[1], 4'b0000};
                rdata_o = {{(W-16){1'b0}}, shifted[15:0]};
            end
            LsByte, LsByteU: begin
                be_o    = BeByte0 << addr_i;
                wdata_o = {(W/8){s_data_i[7:0]}};
                shifted = rdata_i >> {addr_i, 3'b000};
                rdata_o = {{(W-8){1'b0}}, shifted[7:0]};
            end
            default: begin
                be_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns mem-stage load/store requests into single
// bus transfers, stalling the pipeline while a transfer is outstanding.
// Optional build macro DMEM_ALIGN_CHECK_EN rejects misaligned word/half
// accesses with a bus_err pulse instead of silently aligning them.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef L_S_MODE_W
`define L_S_MODE_W 3
`endif

module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned W           = `WORD_WIDTH,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_en,
    input  logic [W-1:0]           l_addr,
    output logic [W-1:0]           l_data,
    input  logic                   store_en,
    input  logic [W-1:0]           s_addr,
    input  logic [W-1:0]           s_data,
    input  logic [`L_S_MODE_W-1:0] l_s_mode,
    output logic                   stall,
    output logic                   bus_req,
    output logic                   bus_we,
    output logic [W-1:0]           bus_addr,
    output logic [3:0]             bus_be,
    output logic [W-1:0]           bus_wdata,
    input  logic                   bus_ack,
    input  logic [W-1:0]           bus_rdata,
    output logic                   bus_err
);

    dmem_state_e         state_q, state_d;
    logic [31:0]         cnt_q, cnt_d;
    logic                load_pend_q, load_pend_d;
    logic [W-1:0]        l_addr_q, l_addr_d;
    logic [LsModeW-1:0]  mode_q, mode_d;
    logic                stall_q, stall_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [W-1:0]        bus_addr_q, bus_addr_d;
    logic [BeW-1:0]      bus_be_q, bus_be_d;
    logic [W-1:0]        bus_wdata_q, bus_wdata_d;
    logic                bus_err_q, bus_err_d;
    logic [W-1:0]        l_data_q, l_data_d;

    logic [W-1:0]        first_addr;
    logic [1:0]          lane_addr;
    logic [LsModeW-1:0]  lane_mode;
    logic [BeW-1:0]      lane_be;
    logic [W-1:0]        lane_wdata;
    logic [W-1:0]        lane_rdata;
    logic                first_mis;
    logic                load_mis;
    logic                timeout_hit;

    // A store always goes first when both requests arrive together.
    assign first_addr = store_en ? s_addr : l_addr;
    // In IDLE steer for the incoming request; otherwise for the latched load.
    assign lane_addr  = (state_q == StIdle) ? first_addr[1:0] : l_addr_q[1:0];
    assign lane_mode  = (state_q == StIdle) ? l_s_mode : mode_q;

`ifdef DMEM_ALIGN_CHECK_EN
    assign first_mis = misaligned(l_s_mode, first_addr[1:0]);
    assign load_mis  = misaligned(mode_q, l_addr_q[1:0]);
`else
    assign first_mis = 1'b0;
    assign load_mis  = 1'b0;
`endif

    assign timeout_hit = (TIMEOUT_CYC != 0) && ((cnt_q + 32'd1) == 32'(TIMEOUT_CYC));

    dmem_ctrl_lane #(
        .W (W)
    ) u_lane (
        .mode_i   (lane_mode),
        .addr_i   (lane_addr),
        .s_data_i (s_data),
        .rdata_i  (bus_rdata),
        .be_o     (lane_be),
        .wdata_o  (lane_wdata),
        .rdata_o  (lane_rdata)
    );

    // Next-state and registered-output logic for the transfer FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_pend_d = load_pend_q;
        l_addr_d    = l_addr_q;
        mode_d      = mode_q;
        stall_d     = stall_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        bus_err_d   = 1'b0;
        l_data_d    = l_data_q;
        unique case (state_q)
            StIdle: begin
                if (store_en || load_en) begin
                    l_addr_d    = l_addr;
                    mode_d      = l_s_mode;
                    load_pend_d = store_en && load_en;
                    cnt_d       = '0;
                    if (!mode_valid(l_s_mode)) begin
                        state_d     = StDone;
                        l_data_d    = '0;
                        load_pend_d = 1'b0;
                    end else if (first_mis) begin
                        state_d     = StDone;
                        bus_err_d   = 1'b1;
                        l_data_d    = '0;
                        load_pend_d = 1'b0;
                    end else begin
                        state_d     = store_en ? StStore : StLoad;
                        stall_d     = 1'b1;
                        bus_req_d   = 1'b1;
                        bus_we_d    = store_en;
                        bus_addr_d  = {first_addr[W-1:2], 2'b00};
                        bus_be_d    = lane_be;
                        bus_wdata_d = store_en ? lane_wdata : '0;
                    end
                end
            end
            StStore: begin
                if (bus_ack) begin
                    if (load_pend_q && !load_mis) begin
                        // Chain straight into the load; stall stays high.
                        state_d     = StLoad;
                        load_pend_d = 1'b0;
                        cnt_d       = '0;
                        bus_we_d    = 1'b0;
                        bus_addr_d  = {l_addr_q[W-1:2], 2'b00};
                        bus_be_d    = lane_be;
                        bus_wdata_d = '0;
                    end else begin
                        state_d     = StDone;
                        stall_d     = 1'b0;
                        bus_req_d   = 1'b0;
                        bus_we_d    = 1'b0;
                        if (load_pend_q) begin
                            bus_err_d = 1'b1;
                            l_data_d  = '0;
                        end
                        load_pend_d = 1'b0;
                    end
                end else if (timeout_hit) begin
                    state_d     = StDone;
                    stall_d     = 1'b0;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_err_d   = 1'b1;
                    l_data_d    = '0;
                    load_pend_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StLoad: begin
                if (bus_ack) begin
                    state_d   = StDone;
                    stall_d   = 1'b0;
                    bus_req_d = 1'b0;
                    l_data_d  = lane_rdata;
                end else if (timeout_hit) begin
                    state_d   = StDone;
                    stall_d   = 1'b0;
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    l_data_d  = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            load_pend_q <= 1'b0;
            l_addr_q    <= '0;
            mode_q      <= '0;
            stall_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            bus_err_q   <= 1'b0;
            l_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            load_pend_q <= load_pend_d;
            l_addr_q    <= l_addr_d;
            mode_q      <= mode_d;
            stall_q     <= stall_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            bus_err_q   <= bus_err_d;
            l_data_q    <= l_data_d;
        end
    end

    assign stall     = stall_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_err   = bus_err_q;
    assign l_data    = l_data_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: table of single transfers plus hand-written
// sequences for chained store/load, timeout, alignment, bad mode and reset.
module tb_dmem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        load_en;
    logic [31:0] l_addr;
    logic [31:0] l_data;
    logic        store_en;
    logic [31:0] s_addr;
    logic [31:0] s_data;
    logic [2:0]  l_s_mode;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_ctrl #(
        .W           (32),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (load_en),
        .l_addr    (l_addr),
        .l_data    (l_data),
        .store_en  (store_en),
        .s_addr    (s_addr),
        .s_data    (s_data),
        .l_s_mode  (l_s_mode),
        .stall     (stall),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        is_store;
        logic [2:0]  mode;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          ack_after;
        logic [31:0] exp_baddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_ldata;
        int          exp_stall;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int stalls;
        int cyc;
        stalls   = 0;
        cyc      = 0;
        store_en = v.is_store;
        load_en  = !v.is_store;
        s_addr   = v.addr;
        l_addr   = v.addr;
        s_data   = v.sdata;
        l_s_mode = v.mode;
        tick();
        store_en = 1'b0;
        load_en  = 1'b0;
        check({v.name, " req"}, {31'b0, bus_req}, 32'd1);
        check({v.name, " we"}, {31'b0, bus_we}, {31'b0, v.is_store});
        check({v.name, " addr"}, bus_addr, v.exp_baddr);
        check({v.name, " be"}, {28'b0, bus_be}, {28'b0, v.exp_be});
        if (v.is_store) check({v.name, " wdata"}, bus_wdata, v.exp_wdata);
        while (stall && cyc < 20) begin
            stalls++;
            if (cyc == v.ack_after) begin
                bus_ack   = 1'b1;
                bus_rdata = v.rdata;
            end
            tick();
            bus_ack = 1'b0;
            cyc++;
        end
        check({v.name, " stall cycles"}, stalls, v.exp_stall);
        check({v.name, " req low"}, {31'b0, bus_req}, 32'd0);
        check({v.name, " l_data"}, l_data, v.exp_ldata);
        tick();
    endtask

    initial begin
        int n;
        int errs;
        int reqs;
        rst_n     = 1'b0;
        load_en   = 1'b0;
        store_en  = 1'b0;
        l_addr    = '0;
        s_addr    = '0;
        s_data    = '0;
        l_s_mode  = 3'd0;
        bus_ack   = 1'b0;
        bus_rdata = '0;

        //            name     st    mode  addr     sdata          rdata          ack baddr    be       wdata          ldata         stall
        vecs[0] = '{"sb103",  1'b1, 3'd3, 32'h103, 32'h000000AB, 32'h0,         0, 32'h100, 4'b1000, 32'hABABABAB, 32'h0,         1};
        vecs[1] = '{"lh202",  1'b0, 3'd1, 32'h202, 32'h0,         32'hBEEF1234, 2, 32'h200, 4'b1100, 32'h0,         32'h0000BEEF, 3};
        vecs[2] = '{"sw10",   1'b1, 3'd0, 32'h010, 32'h12345678, 32'h0,         1, 32'h010, 4'b1111, 32'h12345678, 32'h0000BEEF, 2};
        vecs[3] = '{"lbu31",  1'b0, 3'd4, 32'h031, 32'h0,         32'hA1B2C3D4, 0, 32'h030, 4'b0010, 32'h0,         32'h000000C3, 1};
        vecs[4] = '{"shu40",  1'b1, 3'd2, 32'h040, 32'hFFFF5A5A, 32'h0,         0, 32'h040, 4'b0011, 32'h5A5A5A5A, 32'h000000C3, 1};
        vecs[5] = '{"lw80",   1'b0, 3'd0, 32'h080, 32'h0,         32'hDEADBEEF, 1, 32'h080, 4'b1111, 32'h0,         32'hDEADBEEF, 2};
        vecs[6] = '{"lb83",   1'b0, 3'd3, 32'h083, 32'h0,         32'h11223344, 0, 32'h080, 4'b1000, 32'h0,         32'h00000011, 1};
        vecs[7] = '{"lh84",   1'b0, 3'd1, 32'h084, 32'h0,         32'h11223344, 0, 32'h084, 4'b0011, 32'h0,         32'h00003344, 1};

        // Reset state
        #3;
        check("rst stall", {31'b0, stall}, 32'd0);
        check("rst req", {31'b0, bus_req}, 32'd0);
        check("rst err", {31'b0, bus_err}, 32'd0);
        check("rst addr", bus_addr, 32'd0);
        check("rst ldata", l_data, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Store 0x10 and load 0x14 together: two back-to-back transfers
        reqs     = 0;
        store_en = 1'b1;
        load_en  = 1'b1;
        s_addr   = 32'h10;
        l_addr   = 32'h14;
        s_data   = 32'hCAFEF00D;
        l_s_mode = 3'd0;
        tick();
        store_en = 1'b0;
        load_en  = 1'b0;
        check("dual st stall", {31'b0, stall}, 32'd1);
        check("dual st we", {31'b0, bus_we}, 32'd1);
        check("dual st addr", bus_addr, 32'h10);
        check("dual st wdata", bus_wdata, 32'hCAFEF00D);
        if (bus_req) reqs++;
        bus_ack   = 1'b1;
        bus_rdata = 32'h55667788;
        tick();
        check("dual ld stall", {31'b0, stall}, 32'd1);
        check("dual ld req", {31'b0, bus_req}, 32'd1);
        check("dual ld we", {31'b0, bus_we}, 32'd0);
        check("dual ld addr", bus_addr, 32'h14);
        if (bus_req) reqs++;
        tick();
        bus_ack = 1'b0;
        check("dual done stall", {31'b0, stall}, 32'd0);
        check("dual ldata", l_data, 32'h55667788);
        check("dual transfers", reqs, 32'd2);
        tick();

        // Unknown mode: no transfer, l_data cleared
        load_en  = 1'b1;
        l_addr   = 32'h20;
        l_s_mode = 3'd7;
        tick();
        load_en = 1'b0;
        check("badmode req", {31'b0, bus_req}, 32'd0);
        check("badmode stall", {31'b0, stall}, 32'd0);
        check("badmode ldata", l_data, 32'd0);
        tick();

        // Timeout with no ack after a load left l_data nonzero
        run_vec(vecs[5]);
        load_en  = 1'b1;
        l_addr   = 32'h50;
        l_s_mode = 3'd0;
        tick();
        load_en = 1'b0;
        n    = 0;
        errs = 0;
        while (bus_req && n < 20) begin
            n++;
            tick();
            if (bus_err) errs++;
        end
        tick();
        if (bus_err) errs++;
        tick();
        if (bus_err) errs++;
        check("timeout req cycles", n, 32'd4);
        check("timeout err pulses", errs, 32'd1);
        check("timeout ldata", l_data, 32'd0);

        // Misaligned word load at 0x6
        load_en  = 1'b1;
        l_addr   = 32'h6;
        l_s_mode = 3'd0;
        tick();
        load_en = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        check("misalign req", {31'b0, bus_req}, 32'd0);
        check("misalign err", {31'b0, bus_err}, 32'd1);
        tick();
        check("misalign err pulse", {31'b0, bus_err}, 32'd0);
`else
        check("unaligned req", {31'b0, bus_req}, 32'd1);
        check("unaligned addr", bus_addr, 32'h4);
        check("unaligned err", {31'b0, bus_err}, 32'd0);
        bus_ack   = 1'b1;
        bus_rdata = 32'h01020304;
        tick();
        bus_ack = 1'b0;
        check("unaligned ldata", l_data, 32'h01020304);
`endif
        tick();

        // Reset during a load wait, then a late ack
        load_en  = 1'b1;
        l_addr   = 32'h60;
        l_s_mode = 3'd0;
        tick();
        load_en = 1'b0;
        check("rstmid req before", {31'b0, bus_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid req", {31'b0, bus_req}, 32'd0);
        check("rstmid stall", {31'b0, stall}, 32'd0);
        tick();
        rst_n     = 1'b1;
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFFFFFF;
        tick();
        bus_ack = 1'b0;
        check("late ack req", {31'b0, bus_req}, 32'd0);
        check("late ack stall", {31'b0, stall}, 32'd0);
        tick();
        check("late ack ldata", l_data, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
